fetch_controller: RTL and testbench

// Sequences instruction fetch for the RV32 core: drives PC update (pc_next/pc_stall) of program_counter,

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_wait_timer.sv | 30 +++
 rtl/fetch_controller.sv | 164 ++++++++++++++++
 tb/tb_fetch_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and the instruction size used for sequential PC advance.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles spent waiting for instruction read data. Flags expiry once the
// count reaches WAIT_LIMIT. The count saturates there until it is cleared.
module fetch_wait_timer #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int               CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding I-port request, single-word
// buffer toward decode, redirect handling and a sticky memory-timeout error.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    WAIT_LIMIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  pc_stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  pipe_stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fetch_err
);

    if (WAIT_LIMIT < 1 || RESET_VECTOR[1:0] != 2'b00) begin : g_param_check
        $error("fetch_controller: WAIT_LIMIT must be >= 1 and RESET_VECTOR word aligned");
    end

    fetch_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_fetch_err;
    logic                  r_kill;
    logic [DATA_WIDTH-1:0] r_tgt;

    logic                  w_timer_clear;
    logic                  w_timer_en;
    logic                  w_expire;
    logic                  w_pc_stall;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc      = pc + DATA_WIDTH'(INSTR_BYTES);
    assign w_timer_clear = (r_state == ST_REQ) && imem_gnt;
    assign w_timer_en    = (r_state == ST_WAIT) && !imem_rvalid;

    fetch_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    // PC load control: the PC only moves when a redirect lands or decode consumes a word.
    always_comb begin
        w_pc_stall = 1'b1;
        w_pc_next  = w_pc_inc;
        case (r_state)
            ST_REQ: begin
                if (redirect && !imem_gnt) begin
                    w_pc_stall = 1'b0;
                    w_pc_next  = redirect_pc;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid && (r_kill || redirect)) begin
                    w_pc_stall = 1'b0;
                    w_pc_next  = redirect ? redirect_pc : r_tgt;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_pc_stall = 1'b0;
                    w_pc_next  = redirect_pc;
                end else if (!pipe_stall) begin
                    w_pc_stall = 1'b0;
                end
            end
            default: begin
                w_pc_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_kill        <= 1'b0;
            r_tgt         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        r_state <= ST_WAIT;
                        // Request already accepted: its response must be dropped later.
                        if (redirect) begin
                            r_kill <= 1'b1;
                            r_tgt  <= redirect_pc;
                        end
                    end else if (redirect) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill || redirect) begin
                            r_kill  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            r_kill <= 1'b1;
                            r_tgt  <= redirect_pc;
                        end
                        if (w_expire) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= ST_ERR;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (!pipe_stall) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_stall    = w_pc_stall;
    assign pc_next     = w_pc_next;
    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: PC register and I-port memory models around the
// DUT, with a scoreboard of expected instruction words.
module tb_fetch_controller;

    localparam int DW = 32;
    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc_next;
    logic          pc_stall;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          pipe_stall = 1'b0;
    logic          redirect = 1'b0;
    logic [DW-1:0] redirect_pc = '0;
    logic          fetch_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int            rise_cyc[$];
    int            n_words = 0;
    int            cyc = 0;

    int            gnt_delay = 0;
    int            rv_delay = 0;
    logic          rv_enable = 1'b1;

    fetch_controller #(
        .DATA_WIDTH   (DW),
        .RESET_VECTOR (32'h0),
        .WAIT_LIMIT   (WL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pipe_stall  (pipe_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // program_counter model: loads pc_next whenever the DUT releases the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= '0;
        else if (!pc_stall) pc <= pc_next;
    end

    // I-port memory model: grant after gnt_delay REQ cycles, data rv_delay+1 cycles later.
    initial begin
        logic          rv_pending;
        int            rv_cnt;
        int            gnt_cnt;
        logic [DW-1:0] rv_addr;
        rv_pending  = 1'b0;
        rv_cnt      = 0;
        gnt_cnt     = 0;
        rv_addr     = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst) begin
                rv_pending = 1'b0;
                gnt_cnt    = 0;
            end else begin
                if (rv_pending) begin
                    if (rv_cnt == 0) begin
                        imem_rvalid = rv_enable;
                        imem_rdata  = mem_word(rv_addr);
                        rv_pending  = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (imem_req) begin
                    if (gnt_cnt >= gnt_delay) begin
                        imem_gnt   = 1'b1;
                        rv_pending = 1'b1;
                        rv_addr    = imem_addr;
                        rv_cnt     = rv_delay;
                        gnt_cnt    = 0;
                    end else begin
                        gnt_cnt++;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: each new instr_valid pulse must match the oldest expected word.
    initial begin
        logic          prev_v;
        logic [DW-1:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
                n_words++;
                rise_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_instr: got %h, required no word", instr);
                end else begin
                    e = exp_q.pop_front();
                    if (instr !== e) begin
                        errors++;
                        $display("FAIL sb_instr: got %h, required %h", instr, e);
                    end
                end
            end
            prev_v = instr_valid;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        redirect   = 1'b0;
        pipe_stall = 1'b0;
        rv_enable  = 1'b1;
        gnt_delay  = 0;
        rv_delay   = 0;
        exp_q.delete();
        rise_cyc.delete();
        n_words    = 0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_pc_stall", 32'(pc_stall), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (n_words < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_words_count", 32'(n_words >= n), 32'd1);
    endtask

    task automatic wait_gnt(input int budget);
        int k = 0;
        @(negedge clk);
        while (imem_gnt !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_gnt_seen", 32'(imem_gnt), 32'd1);
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        @(negedge clk);
        while (imem_req !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_req_seen", 32'(imem_req), 32'd1);
    endtask

    initial begin
        #1;
        // 1: back-to-back fetches, one word every 3 cycles
        do_reset();
        exp_q.push_back(mem_word(32'h0));
        exp_q.push_back(mem_word(32'h4));
        exp_q.push_back(mem_word(32'h8));
        release_rst();
        wait_words(3, 40);
        if (rise_cyc.size() >= 3) begin
            check("t1_gap01", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
            check("t1_gap12", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);
        end
        check("t1_pc", pc, 32'h8);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: delayed grant keeps the request stable
        do_reset();
        gnt_delay = 3;
        exp_q.push_back(mem_word(32'h0));
        release_rst();
        wait_req(10);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_req_held", 32'(imem_req), 32'd1);
            check("t2_addr_stable", imem_addr, 32'h0);
            check("t2_pc_stall", 32'(pc_stall), 32'd1);
        end
        wait_words(1, 20);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: decode stall holds the buffered word
        do_reset();
        pipe_stall = 1'b1;
        exp_q.push_back(mem_word(32'h0));
        release_rst();
        wait_words(1, 20);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_instr_held", instr, mem_word(32'h0));
            check("t3_valid_held", 32'(instr_valid), 32'd1);
            check("t3_pc_held", pc, 32'h0);
            check("t3_no_req", 32'(imem_req), 32'd0);
        end
        #1;
        pipe_stall = 1'b0;
        exp_q.push_back(mem_word(32'h4));
        wait_words(2, 20);
        check("t3_pc_after", pc, 32'h4);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: redirect while waiting, response arrives later and is dropped
        do_reset();
        rv_delay = 2;
        exp_q.push_back(mem_word(32'h100));
        release_rst();
        wait_gnt(10);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        check("t4_wait_stall", 32'(pc_stall), 32'd1);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("t4_wait_stall2", 32'(pc_stall), 32'd1);
        @(negedge clk);
        check("t4_drop_load", 32'(pc_stall), 32'd0);
        check("t4_drop_pc_next", pc_next, 32'h100);
        @(negedge clk);
        check("t4_no_valid", 32'(instr_valid), 32'd0);
        check("t4_pc", pc, 32'h100);
        wait_req(10);
        check("t4_new_addr", imem_addr, 32'h100);
        wait_words(1, 20);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: redirect coincident with rvalid, then redirect in HOLD under stall
        do_reset();
        exp_q.push_back(mem_word(32'h200));
        release_rst();
        wait_gnt(10);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        check("t5_load", 32'(pc_stall), 32'd0);
        check("t5_pc_next", pc_next, 32'h200);
        @(posedge clk);
        #1;
        redirect   = 1'b0;
        pipe_stall = 1'b1;
        @(negedge clk);
        check("t5_no_valid", 32'(instr_valid), 32'd0);
        check("t5_pc", pc, 32'h200);
        wait_words(1, 20);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        #1;
        check("t5_hold_load", 32'(pc_stall), 32'd0);
        check("t5_hold_pc_next", pc_next, 32'h400);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("t5_hold_valid_drop", 32'(instr_valid), 32'd0);
        check("t5_hold_pc", pc, 32'h400);
        pipe_stall = 1'b0;
        exp_q.push_back(mem_word(32'h400));
        wait_words(2, 20);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: memory never answers -> sticky fetch_err
        do_reset();
        rv_enable = 1'b0;
        release_rst();
        wait_gnt(10);
        repeat (4) @(negedge clk);
        check("t6_err_early", 32'(fetch_err), 32'd0);
        check("t6_wait_stall", 32'(pc_stall), 32'd1);
        repeat (2) @(negedge clk);
        check("t6_err_set", 32'(fetch_err), 32'd1);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_err_sticky", 32'(fetch_err), 32'd1);
            check("t6_no_req", 32'(imem_req), 32'd0);
            check("t6_stall", 32'(pc_stall), 32'd1);
        end
        redirect = 1'b0;
        check("t6_pc_unmoved", pc, 32'h0);
        check("t6_no_words", 32'(n_words), 32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
